skip_1x2: RTL and testbench

//  Vertical 2:1 line decimation for the RGB888 video path; sits directly downstream of skip_2x1.

---
 rtl/skip_1x2_pkg.sv | 24 ++
 rtl/skip_1x2_size_meter.sv | 83 ++++++++
 rtl/skip_1x2.sv | 122 ++++++++++++
 tb/tb_skip_1x2.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skip_1x2_pkg.sv
// -----------------------------------------------------------------------------
// skip_1x2_pkg
// Shared constants for the RGB888 skip stages (skip_2x1 horizontal, skip_1x2
// vertical) and a small helper deciding whether a line survives decimation.
// -----------------------------------------------------------------------------
package skip_1x2_pkg;

    // Colour channel width of the RGB888 path.
    localparam int RGB_W      = 8;

    // Default width of the pixel/line counters and the size outputs.
    localparam int CNT_W_DEF  = 12;

    // Bit positions inside the shared image_mode word.
    localparam int MODE_HSKIP = 0;
    localparam int MODE_VSKIP = 1;

    // A line is kept when vertical skip is off, or when it is an even line
    // of the frame (parity 0 = first line after vs).
    function automatic logic keep_line(input logic vskip_en, input logic parity);
        return ~vskip_en | ~parity;
    endfunction

endpackage

// File: rtl/skip_1x2_size_meter.sv
// -----------------------------------------------------------------------------
// skip_1x2_size_meter
// Measures the size of the frame seen on a de stream: the number of de cycles
// in the last completed line and the number of completed lines. The values of
// the frame just finished are published on every frame_start together with a
// one-cycle stat_valid pulse.
//
// Ports
//   clock         in   1      pixel clock
//   reset         in   1      synchronous, active-high reset
//   frame_start   in   1      single-cycle frame start strobe
//   de            in   1      data enable of the stream being measured
//   width_o       out  CNT_W  de count of the last completed line of last frame
//   height_o      out  CNT_W  completed-line count of last frame
//   stat_valid_o  out  1      pulses for one cycle when width_o/height_o update
// -----------------------------------------------------------------------------
module skip_1x2_size_meter
    import skip_1x2_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             de,
    output logic [CNT_W-1:0] width_o,
    output logic [CNT_W-1:0] height_o,
    output logic             stat_valid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             de_d_reg;
    logic [CNT_W-1:0] pix_cnt_reg;
    logic [CNT_W-1:0] line_cnt_reg;
    logic [CNT_W-1:0] width_q_reg;
    logic [CNT_W-1:0] width_reg;
    logic [CNT_W-1:0] height_reg;
    logic             stat_valid_reg;
    logic             line_done;

    // Falling edge of the measured de closes a line.
    assign line_done = de_d_reg & ~de;

    always_ff @(posedge clock) begin
        if (reset) begin
            de_d_reg       <= 1'b0;
            pix_cnt_reg    <= '0;
            line_cnt_reg   <= '0;
            width_q_reg    <= '0;
            width_reg      <= '0;
            height_reg     <= '0;
            stat_valid_reg <= 1'b0;
        end else begin
            stat_valid_reg <= frame_start;
            if (frame_start) begin
                width_reg    <= width_q_reg;
                height_reg   <= line_cnt_reg;
                pix_cnt_reg  <= '0;
                line_cnt_reg <= '0;
                // Forget the de history so a line cut short by vs does not
                // complete (and get counted) in the new frame.
                de_d_reg     <= 1'b0;
            end else begin
                de_d_reg <= de;
                if (line_done) begin
                    width_q_reg <= pix_cnt_reg;
                    pix_cnt_reg <= '0;
                    if (line_cnt_reg != CNT_MAX) begin
                        line_cnt_reg <= line_cnt_reg + 1'b1;
                    end
                end else if (de && (pix_cnt_reg != CNT_MAX)) begin
                    pix_cnt_reg <= pix_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign width_o      = width_reg;
    assign height_o     = height_reg;
    assign stat_valid_o = stat_valid_reg;

endmodule

// File: rtl/skip_1x2.sv
// -----------------------------------------------------------------------------
// skip_1x2
// Vertical 2:1 line decimation for the RGB888 video path, placed right after
// skip_2x1. All stream signals are delayed by one clock; when the vertical
// skip bit of the per-frame mode word is set, de_o is suppressed on every odd
// line of the frame (the first line after vs is kept). The output frame size
// is measured and reported once per frame.
//
// Ports
//   clock                 in   1      pixel clock
//   reset                 in   1      synchronous, active-high reset
//   vs_i / hs_i / de_i    in   1      syncs and data enable from skip_2x1
//   rgb_r_i/_g_i/_b_i     in   8      pixel colour
//   image_mode_i          in   8      mode word, captured at each frame start
//   vs_o / hs_o           out  1      syncs delayed one clock
//   de_o                  out  1      de delayed one clock, gated on odd lines
//   rgb_r_o/_g_o/_b_o     out  8      colour delayed one clock (not reset)
//   width_o / height_o    out  CNT_W  kept-line width and kept-line count of
//                                     the previous frame
//   stat_valid_o          out  1      one-cycle pulse on width/height update
// -----------------------------------------------------------------------------
module skip_1x2
    import skip_1x2_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MODE_BIT = MODE_VSKIP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vs_i,
    input  logic             hs_i,
    input  logic             de_i,
    input  logic [RGB_W-1:0] rgb_r_i,
    input  logic [RGB_W-1:0] rgb_g_i,
    input  logic [RGB_W-1:0] rgb_b_i,
    input  logic [7:0]       image_mode_i,
    output logic             vs_o,
    output logic             hs_o,
    output logic             de_o,
    output logic [RGB_W-1:0] rgb_r_o,
    output logic [RGB_W-1:0] rgb_g_o,
    output logic [RGB_W-1:0] rgb_b_o,
    output logic [CNT_W-1:0] width_o,
    output logic [CNT_W-1:0] height_o,
    output logic             stat_valid_o
);

    logic             vs_d_reg;
    logic             hs_d_reg;
    logic             de_d_reg;
    logic             vskip_reg;
    logic             parity_reg;
    logic [RGB_W-1:0] rgb_r_reg;
    logic [RGB_W-1:0] rgb_g_reg;
    logic [RGB_W-1:0] rgb_b_reg;
    logic             frame_start;
    logic             line_end;
    logic             de_out;
    logic             mode_unused;

    // Only one bit of the mode word concerns this stage; the others belong
    // to neighbouring stages.
    assign mode_unused = ^image_mode_i;

    assign frame_start = vs_i & ~vs_d_reg;
    // The incoming de is the ungated line enable, so each falling edge is a
    // genuine end of line.
    assign line_end    = de_d_reg & ~de_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            vs_d_reg   <= 1'b0;
            hs_d_reg   <= 1'b0;
            de_d_reg   <= 1'b0;
            vskip_reg  <= 1'b0;
            parity_reg <= 1'b0;
        end else begin
            vs_d_reg <= vs_i;
            hs_d_reg <= hs_i;
            de_d_reg <= de_i;
            // Frame start wins over a coincident line end: a line cut off by
            // vs must not leave the new frame on odd parity.
            if (frame_start) begin
                vskip_reg  <= image_mode_i[MODE_BIT];
                parity_reg <= 1'b0;
            end else if (line_end) begin
                parity_reg <= ~parity_reg;
            end
        end
    end

    // Colour is pure pipeline data and is qualified by de_o downstream.
    always_ff @(posedge clock) begin
        rgb_r_reg <= rgb_r_i;
        rgb_g_reg <= rgb_g_i;
        rgb_b_reg <= rgb_b_i;
    end

    // Parity only changes on the edge where de_d falls, so the gate is
    // stable across every active line.
    assign de_out = de_d_reg & keep_line(vskip_reg, parity_reg);

    skip_1x2_size_meter #(
        .CNT_W(CNT_W)
    ) u_size_meter (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .de          (de_out),
        .width_o     (width_o),
        .height_o    (height_o),
        .stat_valid_o(stat_valid_o)
    );

    assign vs_o    = vs_d_reg;
    assign hs_o    = hs_d_reg;
    assign de_o    = de_out;
    assign rgb_r_o = rgb_r_reg;
    assign rgb_g_o = rgb_g_reg;
    assign rgb_b_o = rgb_b_reg;

endmodule

// File: tb/tb_skip_1x2.sv
`timescale 1ns/1ps
module tb_skip_1x2;

    localparam int CNT_W = 12;

    logic             clock = 1'b0;
    logic             reset;
    logic             vs_i, hs_i, de_i;
    logic [7:0]       rgb_r_i, rgb_g_i, rgb_b_i;
    logic [7:0]       image_mode_i;
    logic             vs_o, hs_o, de_o;
    logic [7:0]       rgb_r_o, rgb_g_o, rgb_b_o;
    logic [CNT_W-1:0] width_o, height_o;
    logic             stat_valid_o;

    always #5 clock = ~clock;

    skip_1x2 #(
        .CNT_W   (CNT_W),
        .MODE_BIT(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vs_i        (vs_i),
        .hs_i        (hs_i),
        .de_i        (de_i),
        .rgb_r_i     (rgb_r_i),
        .rgb_g_i     (rgb_g_i),
        .rgb_b_i     (rgb_b_i),
        .image_mode_i(image_mode_i),
        .vs_o        (vs_o),
        .hs_o        (hs_o),
        .de_o        (de_o),
        .rgb_r_o     (rgb_r_o),
        .rgb_g_o     (rgb_g_o),
        .rgb_b_o     (rgb_b_o),
        .width_o     (width_o),
        .height_o    (height_o),
        .stat_valid_o(stat_valid_o)
    );

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] rgb;
    } stream_t;

    typedef struct packed {
        logic [CNT_W-1:0] w;
        logic [CNT_W-1:0] h;
    } stat_t;

    stream_t exp_q[$];
    stat_t   stat_q[$];
    stream_t pending;
    bit      have_pending = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state of the bench model.
    int exp_wq    = 0;   // width of last kept line
    int exp_lines = 0;   // kept lines in current frame
    int line_idx  = 0;   // line number inside current frame
    bit frame_vskip = 1'b0;

    // One cycle of stimulus. The expectation for this cycle is queued at the
    // next rising edge, which is when the DUT registers it.
    task automatic drive(input logic rst, input logic vs, input logic hs,
                         input logic de, input logic exp_de);
        logic [23:0] px;
        @(posedge clock);
        if (have_pending) exp_q.push_back(pending);
        #1;
        px      = 24'($urandom);
        reset   = rst;
        vs_i    = vs;
        hs_i    = hs;
        de_i    = de;
        {rgb_r_i, rgb_g_i, rgb_b_i} = px;
        pending.vs   = rst ? 1'b0 : vs;
        pending.hs   = rst ? 1'b0 : hs;
        pending.de   = rst ? 1'b0 : exp_de;
        pending.rgb  = px;
        have_pending = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // vs pulse; the statistics of the frame just ended are expected next.
    task automatic frame_start_seq(input logic [7:0] mode);
        stat_t s;
        image_mode_i = mode;
        s.w = 12'(exp_wq);
        s.h = 12'(exp_lines);
        stat_q.push_back(s);
        exp_lines   = 0;
        line_idx    = 0;
        frame_vskip = mode[1];
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    // One line of npix continuous de; stop_at >= 0 cuts the line right
    // before that pixel (caller then raises vs).
    task automatic send_line(input int npix, input int stop_at);
        bit keep;
        keep = !frame_vskip || (line_idx % 2 == 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        for (int p = 0; p < npix; p++) begin
            if (p == stop_at) return;
            drive(1'b0, 1'b0, 1'b0, 1'b1, keep);
        end
        idle(3);
        if (keep && npix > 0) begin
            exp_wq = (npix > 4095) ? 4095 : npix;
            if (exp_lines < 4095) exp_lines++;
        end
        line_idx++;
    endtask

    task automatic send_frame(input logic [7:0] mode, input logic [7:0] mid_mode,
                              input int mid_line, input int npix, input int nlines);
        frame_start_seq(mode);
        for (int l = 0; l < nlines; l++) begin
            if (l == mid_line) image_mode_i = mid_mode;
            send_line(npix, -1);
        end
    endtask

    // Scoreboard consumer: compares every stream cycle and every stat pulse.
    task automatic monitor();
        stream_t e, got;
        stat_t   s;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got.vs  = vs_o;
                got.hs  = hs_o;
                got.de  = de_o;
                got.rgb = {rgb_r_o, rgb_g_o, rgb_b_o};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL stream @%0t: got vs/hs/de/rgb=%b%b%b/%h required %b%b%b/%h",
                             $time, got.vs, got.hs, got.de, got.rgb, e.vs, e.hs, e.de, e.rgb);
                end
            end
            if (stat_valid_o === 1'b1) begin
                checks++;
                if (stat_q.size() == 0) begin
                    errors++;
                    $display("FAIL stat_pulse @%0t: unexpected stat_valid_o, none required", $time);
                end else begin
                    s = stat_q.pop_front();
                    if (width_o !== s.w || height_o !== s.h) begin
                        errors++;
                        $display("FAIL stat_value @%0t: got %0d x %0d required %0d x %0d",
                                 $time, width_o, height_o, s.w, s.h);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        image_mode_i = 8'h00;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset_vs: got %b required 0", vs_o); end
        checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL reset_hs: got %b required 0", hs_o); end
        checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_de: got %b required 0", de_o); end
        checks++; if (width_o !== 12'd0) begin errors++; $display("FAIL reset_width: got %0d required 0", width_o); end
        checks++; if (height_o !== 12'd0) begin errors++; $display("FAIL reset_height: got %0d required 0", height_o); end
        checks++; if (stat_valid_o !== 1'b0) begin errors++; $display("FAIL reset_stat: got %b required 0", stat_valid_o); end
        exp_wq = 0; exp_lines = 0; frame_vskip = 1'b0;
        idle(3);
    endtask

    task automatic test_passthrough();
        send_frame(8'h00, 8'h00, -1, 640, 4);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd640 || height_o !== 12'd4) begin
            errors++;
            $display("FAIL passthrough_size: got %0d x %0d required 640 x 4", width_o, height_o);
        end
    endtask

    task automatic test_vskip();
        send_frame(8'h02, 8'h02, -1, 64, 48);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd64 || height_o !== 12'd24) begin
            errors++;
            $display("FAIL vskip_size: got %0d x %0d required 64 x 24", width_o, height_o);
        end
        // Odd line count, horizontal bit also set (must be ignored here).
        send_frame(8'h03, 8'h03, -1, 40, 9);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd40 || height_o !== 12'd5) begin
            errors++;
            $display("FAIL vskip_odd_size: got %0d x %0d required 40 x 5", width_o, height_o);
        end
    endtask

    task automatic test_mode_change();
        send_frame(8'h00, 8'h02, 5, 32, 12);
        frame_start_seq(8'h02);
        checks++;
        if (width_o !== 12'd32 || height_o !== 12'd12) begin
            errors++;
            $display("FAIL mode_change_cur: got %0d x %0d required 32 x 12", width_o, height_o);
        end
        for (int l = 0; l < 12; l++) send_line(32, -1);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd32 || height_o !== 12'd6) begin
            errors++;
            $display("FAIL mode_change_next: got %0d x %0d required 32 x 6", width_o, height_o);
        end
    endtask

    task automatic test_truncate();
        frame_start_seq(8'h02);
        for (int l = 0; l < 7; l++) send_line(48, -1);
        send_line(48, 30);
        frame_start_seq(8'h02);
        checks++;
        if (width_o !== 12'd48 || height_o !== 12'd4) begin
            errors++;
            $display("FAIL trunc_vskip_size: got %0d x %0d required 48 x 4", width_o, height_o);
        end
        for (int l = 0; l < 3; l++) send_line(48, -1);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd48 || height_o !== 12'd2) begin
            errors++;
            $display("FAIL trunc_vskip_next: got %0d x %0d required 48 x 2", width_o, height_o);
        end
        for (int l = 0; l < 7; l++) send_line(20, -1);
        send_line(20, 10);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd20 || height_o !== 12'd7) begin
            errors++;
            $display("FAIL trunc_kept_size: got %0d x %0d required 20 x 7", width_o, height_o);
        end
        for (int l = 0; l < 2; l++) send_line(20, -1);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd20 || height_o !== 12'd2) begin
            errors++;
            $display("FAIL trunc_kept_next: got %0d x %0d required 20 x 2", width_o, height_o);
        end
    endtask

    task automatic test_saturation();
        send_frame(8'h00, 8'h00, -1, 4100, 1);
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd4095 || height_o !== 12'd1) begin
            errors++;
            $display("FAIL saturation_size: got %0d x %0d required 4095 x 1", width_o, height_o);
        end
    endtask

    task automatic test_reset_midline();
        frame_start_seq(8'h00);
        send_line(50, -1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 40; i++) begin
            drive(i == 20, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i == 20) begin
                exp_wq = 0; exp_lines = 0; frame_vskip = 1'b0;
            end
            if (i == 21) begin
                #1;
                checks++;
                if (de_o !== 1'b0 || width_o !== 12'd0 || height_o !== 12'd0 || stat_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL midline_reset: got de=%b w=%0d h=%0d sv=%b required 0/0/0/0",
                             de_o, width_o, height_o, stat_valid_o);
                end
            end
        end
        idle(3);
        exp_wq = 19; exp_lines = 1;
        frame_start_seq(8'h00);
        checks++;
        if (width_o !== 12'd19 || height_o !== 12'd1) begin
            errors++;
            $display("FAIL midline_resume: got %0d x %0d required 19 x 1", width_o, height_o);
        end
    endtask

    initial begin
        reset = 1'b1; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0;
        rgb_r_i = '0; rgb_g_i = '0; rgb_b_i = '0; image_mode_i = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_passthrough();
        test_vskip();
        test_mode_change();
        test_truncate();
        test_saturation();
        test_reset_midline();
        idle(4);
        @(posedge clock);
        if (have_pending) exp_q.push_back(pending);
        have_pending = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (stat_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d stat / %0d stream entries left, required 0 / 0",
                     stat_q.size(), exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
